pool_arbiter: RTL
=================

# pool_arbiter

Registered, conflict-aware writeback arbiter between the five execution units (alu, fpu, imm, jump, mov) and the conveyor. Each unit presents one atomic bundle of stamp and take lanes under a valid/ready handshake. Lane overlaps are never resolved by silently overriding one unit with another. Instead, each cycle the block grants a lane-disjoint subset of units in round-robin order, back-pressures the rest, and drives the merged bundle to the conveyor one cycle later.

## Interface
Parameters:
- NU, 5, number of requesting units; index 0=alu, 1=fpu, 2=imm, 3=jump, 4=mov.
- NL, 8, register lanes a–h.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- unit_valid  in  NU  unit u presents a bundle.
- unit_ready  out  NU  combinational grant; a transfer occurs when valid[u] & ready[u].
- unit_stamp_flat  in  NU*24  unit u stamps at [u*24 +: 24], lane l at [l*3 +: 3].
- unit_stamp_in  in  NU*8  unit u stamp lane enables at [u*8 +: 8].
- unit_take_flat  in  NU*40  unit u takes at [u*40 +: 40], lane l at [l*5 +: 5].
- unit_take_in  in  NU*8  unit u take lane enables at [u*8 +: 8].
- conveyor_stall  in  1  conveyor cannot accept this cycle.
- conveyor_stamp_flat  out  24  registered merged stamps.
- conveyor_stamp_in  out  8  registered merged stamp enables.
- conveyor_take_flat  out  40  registered merged takes.
- conveyor_take_in  out  8  registered merged take enables.
- conflict_cnt  out  CNT_W  saturating count of conflict cycles.

## Operation
- Footprint of unit u: S_u = stamp_in[u], T_u = take_in[u]. Units u and v conflict iff (S_u & S_v) | (T_u & T_v) is nonzero.
- The arbitration pointer rr_ptr is 3 bits, range 0..NU-1.
- Greedy scan, combinational, each cycle with conveyor_stall=0:
  - Visit units in order rr_ptr, rr_ptr+1, … modulo NU.
  - Keep claimed masks CS and CT, both starting at 0.
  - Unit u is granted iff valid[u] and (S_u & CS)==0 and (T_u & CT)==0.
  - On grant: CS |= S_u and CT |= T_u.
- A bundle is atomic: all of its lanes are granted or none.
- A valid unit with S_u=T_u=0 is always granted and contributes nothing.
- unit_ready[u] = grant[u]. It depends on current inputs and rr_ptr only.
- A unit that is not granted holds valid and its bundle stable until granted. The block does not check this.
- Merge: granted bundles are lane-disjoint, so the next-state outputs are:
  - stamp_in = CS, take_in = CT.
  - Each lane's value is taken from its unique owner; unowned lanes are 0.
- Pointer update:
  - If any unit is granted, rr_ptr <= (first granted unit in scan order + 1) mod NU.
  - Otherwise rr_ptr holds.
- Fairness bound: a continuously valid unit is granted within NU cycles of stall-free operation.
- Conflict counting: if some unit is valid but not granted while conveyor_stall=0, conflict_cnt increments. It saturates at 2^CNT_W-1.
- conveyor_stall=1:
  - unit_ready = 0.
  - Output registers, rr_ptr and conflict_cnt hold.
  - Stalled cycles are not counted as conflicts.

## Timing
- Reset (sync, reset=1 at a rising edge):
  - conveyor_* outputs = 0.
  - rr_ptr = 0.
  - conflict_cnt = 0.
  - unit_ready is forced to 0 while reset=1.
- Latency: a bundle accepted in cycle N appears on conveyor_* in cycle N+1. It is present for exactly one cycle unless cycle N+1 is stalled.
- Idle cycle (no grant, no stall): conveyor_stamp_in = conveyor_take_in = 0 next cycle, and the value fields are 0.
- Reset asserted mid-operation: an in-flight registered bundle is discarded and outputs go to 0. Units see ready=0 and must re-present after reset.
- Same-cycle stall and reset: reset wins.
- Pointer wrap: rr_ptr 4 → 0 after a grant whose first granted unit is 4.
- The conflict counter saturates at 16'hFFFF and holds there.

## Test plan
- Reset then single request:
  - Stimulus: alu valid, S=8'h01, stamp lane a=3'd5.
  - Required: ready[0]=1 the same cycle; next cycle conveyor_stamp_in=8'h01, stamp_flat[2:0]=5; rr_ptr=1.
- Disjoint merge:
  - Stimulus: alu S=8'h03 and mov T=8'h80 (take lane h=5'd17), both valid.
  - Required: both ready; next cycle stamp_in=8'h03, take_in=8'h80, take_flat[39:35]=17; conflict_cnt unchanged.
- Overlap with rotation:
  - Stimulus: fpu and jump both S=8'h10, held valid, rr_ptr=0.
  - Required: cycle 1 grants fpu only and conflict_cnt=1; rr_ptr=2; cycle 2 grants jump.
- Fairness:
  - Stimulus: all five units hold S=8'hFF for 5 cycles from rr_ptr=0.
  - Required: grants in order alu, fpu, imm, jump, mov, one per cycle; conflict_cnt=4.
- Stall:
  - Stimulus: assert conveyor_stall for 3 cycles with alu valid.
  - Required: ready=0; outputs, rr_ptr and conflict_cnt hold; grant in the first unstalled cycle.
- Reset mid-flight:
  - Stimulus: grant imm in cycle N, assert reset in cycle N+1.
  - Required: cycle N+2 outputs all 0, rr_ptr=0, conflict_cnt=0.

Source files
------------

// File: rtl/pool_arbiter_if.sv
// pool_arbiter_if: bundle handshake between the execution units and the
// writeback arbiter, plus the registered merged bundle toward the conveyor.
//
// Handshake: a unit's bundle transfers on a rising clock edge when
// unit_valid[u] and unit_ready[u] are both high. unit_ready is combinational
// and never depends on anything registered except the arbitration pointer.
// A unit that is not granted keeps valid and its bundle steady until granted.
//
// Signals:
//   unit_valid      per unit: bundle present
//   unit_ready      per unit: grant this cycle
//   unit_stamp_flat per unit 8 lanes x 3 bits of stamp value
//   unit_stamp_in   per unit 8 stamp lane enables
//   unit_take_flat  per unit 8 lanes x 5 bits of take value
//   unit_take_in    per unit 8 take lane enables
//   conveyor_stall  conveyor cannot accept this cycle
//   conveyor_*      registered merged bundle
//
// Modports: master = unit/conveyor side (the bench), slave = arbiter.
interface pool_arbiter_if #(
  parameter int NU = 5,
  parameter int NL = 8
);
  logic [NU-1:0]      unit_valid;
  logic [NU-1:0]      unit_ready;
  logic [NU*NL*3-1:0] unit_stamp_flat;
  logic [NU*NL-1:0]   unit_stamp_in;
  logic [NU*NL*5-1:0] unit_take_flat;
  logic [NU*NL-1:0]   unit_take_in;
  logic               conveyor_stall;
  logic [NL*3-1:0]    conveyor_stamp_flat;
  logic [NL-1:0]      conveyor_stamp_in;
  logic [NL*5-1:0]    conveyor_take_flat;
  logic [NL-1:0]      conveyor_take_in;

  modport master (
    output unit_valid, unit_stamp_flat, unit_stamp_in, unit_take_flat,
           unit_take_in, conveyor_stall,
    input  unit_ready, conveyor_stamp_flat, conveyor_stamp_in,
           conveyor_take_flat, conveyor_take_in
  );

  modport slave (
    input  unit_valid, unit_stamp_flat, unit_stamp_in, unit_take_flat,
           unit_take_in, conveyor_stall,
    output unit_ready, conveyor_stamp_flat, conveyor_stamp_in,
           conveyor_take_flat, conveyor_take_in
  );
endinterface

// File: rtl/pool_arbiter.sv
// pool_arbiter: conflict-aware writeback arbiter. Each cycle a greedy
// round-robin scan grants a lane-disjoint subset of valid units; the merged
// bundle is registered toward the conveyor one cycle later.
//
// Ports:
//   clk          clock
//   reset        synchronous active-high reset
//   bus          pool_arbiter_if.slave (unit handshake + conveyor bundle)
//   conflict_cnt saturating count of stall-free cycles with a refused unit
//   rr_ptr       arbitration pointer (debug visibility)
module pool_arbiter #(
  parameter int NU    = 5,
  parameter int NL    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  pool_arbiter_if.slave    bus,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic [2:0]       rr_ptr
);

  localparam logic [2:0] LAST_UNIT = 3'(NU - 1);

  logic [NU-1:0]   grant;
  logic [NL-1:0]   claim_s;
  logic [NL-1:0]   claim_t;
  logic [NL*3-1:0] merge_stamp;
  logic [NL*5-1:0] merge_take;
  logic            first_found;
  logic [2:0]      first_idx;
  logic [2:0]      next_ptr;
  logic            conflict;
  logic [NL-1:0]   cur_s;
  logic [NL-1:0]   cur_t;
  int              scan_idx;

  // Greedy scan starting at rr_ptr. A unit is taken only if none of its
  // lanes are already claimed, so the merge below never has two owners.
  always_comb begin
    grant       = '0;
    claim_s     = '0;
    claim_t     = '0;
    merge_stamp = '0;
    merge_take  = '0;
    first_found = 1'b0;
    first_idx   = '0;
    cur_s       = '0;
    cur_t       = '0;
    scan_idx    = 0;
    for (int k = 0; k < NU; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NU) scan_idx = scan_idx - NU;
      cur_s = bus.unit_stamp_in[scan_idx*NL +: NL];
      cur_t = bus.unit_take_in[scan_idx*NL +: NL];
      if (!reset && !bus.conveyor_stall && bus.unit_valid[scan_idx] &&
          ((cur_s & claim_s) == '0) && ((cur_t & claim_t) == '0)) begin
        grant[scan_idx] = 1'b1;
        claim_s = claim_s | cur_s;
        claim_t = claim_t | cur_t;
        for (int l = 0; l < NL; l++) begin
          if (cur_s[l])
            merge_stamp[l*3 +: 3] = bus.unit_stamp_flat[scan_idx*NL*3 + l*3 +: 3];
          if (cur_t[l])
            merge_take[l*5 +: 5] = bus.unit_take_flat[scan_idx*NL*5 + l*5 +: 5];
        end
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = 3'(scan_idx);
        end
      end
    end
  end

  assign bus.unit_ready = grant;
  assign next_ptr = (first_idx == LAST_UNIT) ? 3'd0 : first_idx + 3'd1;
  // Only meaningful when not stalled; grant is already zero under stall.
  assign conflict = |(bus.unit_valid & ~grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.conveyor_stamp_flat <= '0;
      bus.conveyor_stamp_in   <= '0;
      bus.conveyor_take_flat  <= '0;
      bus.conveyor_take_in    <= '0;
      rr_ptr                  <= '0;
      conflict_cnt            <= '0;
    end else if (!bus.conveyor_stall) begin
      bus.conveyor_stamp_flat <= merge_stamp;
      bus.conveyor_stamp_in   <= claim_s;
      bus.conveyor_take_flat  <= merge_take;
      bus.conveyor_take_in    <= claim_t;
      if (first_found) rr_ptr <= next_ptr;
      if (conflict && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule
